// File: rtl/rll_pkg.sv
// Shared types, widths and the RLL(2,7) code table for rll_decoder.
// Also holds the decode and legal-prefix helpers used by the decoder FSM.
package rll_pkg;

    localparam int CODE_W  = 8;
    localparam int DATA_W  = 4;
    localparam int LEN_W   = 3;
    localparam int CNT_W   = 4;
    localparam int N_CODES = 7;

    typedef enum logic [1:0] {
        S_P4 = 2'd0,
        S_P6 = 2'd1,
        S_P8 = 2'd2
    } state_e;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [CNT_W-1:0]  code_len;
        logic [DATA_W-1:0] data;
        logic [LEN_W-1:0]  len;
    } rll_entry_t;

    typedef struct packed {
        logic              hit;
        logic [DATA_W-1:0] data;
        logic [LEN_W-1:0]  len;
    } rll_dec_t;

    // Codes and data are right-aligned; the first channel bit is the MSB of the code.
    localparam rll_entry_t RLL_TABLE [N_CODES] = '{
        '{8'h08, 4'd4, 4'h3, 3'd2},
        '{8'h04, 4'd4, 4'h2, 3'd2},
        '{8'h08, 4'd6, 4'h3, 3'd3},
        '{8'h24, 4'd6, 4'h2, 3'd3},
        '{8'h04, 4'd6, 4'h0, 3'd3},
        '{8'h24, 4'd8, 4'h2, 3'd4},
        '{8'h08, 4'd8, 4'h3, 3'd4}
    };

    function automatic logic [CODE_W-1:0] rll_mask(input logic [CNT_W-1:0] cnt);
        logic [CODE_W-1:0] m;
        for (int i = 0; i < CODE_W; i++) begin
            m[i] = (i < int'(cnt));
        end
        return m;
    endfunction

    function automatic rll_dec_t rll_lookup(input logic [CODE_W-1:0] code,
                                            input logic [CNT_W-1:0]  cnt);
        rll_dec_t res;
        res = '0;
        for (int i = 0; i < N_CODES; i++) begin
            if ((RLL_TABLE[i].code_len == cnt) &&
                ((code & rll_mask(cnt)) == RLL_TABLE[i].code)) begin
                res.hit  = 1'b1;
                res.data = RLL_TABLE[i].data;
                res.len  = RLL_TABLE[i].len;
            end
        end
        return res;
    endfunction

    // Prefixes that can still grow into a longer legal codeword.
    function automatic logic rll_prefix_legal(input logic [CODE_W-1:0] code,
                                              input logic [CNT_W-1:0]  cnt);
        logic legal;
        case (cnt)
            4'd4:    legal = code[3:0] inside {4'b0010, 4'b1001, 4'b0001, 4'b0000};
            4'd6:    legal = code[5:0] inside {6'b001001, 6'b000010};
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/nrzi_edge_det.sv
// NRZI front end: owns the reference level and registers one code bit per strobe.
// A sync pulse is forwarded in order with the code bits and drops a coincident bit.
module nrzi_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    input  logic line_valid_i,
    input  logic sync_i,
    output logic code_bit_o,
    output logic code_valid_o,
    output logic sync_o
);

    logic ref_q;
    logic bit_q;
    logic valid_q;
    logic sync_q;

    // Reference level tracking and code-bit / sync staging.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ref_q   <= 1'b0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            sync_q <= sync_i;
            if (sync_i) begin
                valid_q <= 1'b0;
            end else if (line_valid_i) begin
                bit_q   <= line_i ^ ref_q;
                ref_q   <= line_i;
                valid_q <= 1'b1;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign code_bit_o   = bit_q;
    assign code_valid_o = valid_q;
    assign sync_o       = sync_q;

endmodule

// File: rtl/rll_decoder.sv
// RLL(2,7) decoder: NRZI front end plus a 4/6/8-bit codeword collection FSM.
// Define RLL_DEC_ERR_CHECK_EN to enable early illegal-prefix detection on err_o.
module rll_decoder
    import rll_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              line_i,
    input  logic              line_valid_i,
    input  logic              sync_i,
    output logic [DATA_W-1:0] data_o,
    output logic [LEN_W-1:0]  len_o,
    output logic              data_valid_o,
    output logic              err_o
);

`ifdef RLL_DEC_ERR_CHECK_EN
    localparam bit ErrCheckEn = 1'b1;
`else
    localparam bit ErrCheckEn = 1'b0;
`endif

    logic              code_bit_s;
    logic              code_valid_s;
    logic              sync_s;
    logic [CODE_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    state_e            state_q;
    logic [DATA_W-1:0] data_q;
    logic [LEN_W-1:0]  len_q;
    logic              dv_q;
    logic              err_q;
    rll_dec_t          dec_s;
    logic              legal_s;

    nrzi_edge_det u_nrzi (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .line_i       (line_i),
        .line_valid_i (line_valid_i),
        .sync_i       (sync_i),
        .code_bit_o   (code_bit_s),
        .code_valid_o (code_valid_s),
        .sync_o       (sync_s)
    );

    // Buffer and count as they would be after absorbing the staged code bit.
    always_comb begin
        buf_d   = (buf_q << 1) | CODE_W'(code_bit_s);
        cnt_d   = cnt_q + 4'd1;
        dec_s   = rll_lookup(buf_d, cnt_d);
        legal_s = rll_prefix_legal(buf_d, cnt_d);
    end

    // Codeword FSM with registered data/length and one-cycle pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_P4;
            buf_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            len_q   <= '0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            dv_q  <= 1'b0;
            err_q <= 1'b0;
            if (sync_s) begin
                buf_q   <= '0;
                cnt_q   <= '0;
                state_q <= S_P4;
            end else if (code_valid_s) begin
                buf_q <= buf_d;
                cnt_q <= cnt_d;
                case (state_q)
                    S_P4: begin
                        if (cnt_d == 4'd4) begin
                            if (dec_s.hit) begin
                                data_q  <= dec_s.data;
                                len_q   <= dec_s.len;
                                dv_q    <= 1'b1;
                                buf_q   <= '0;
                                cnt_q   <= '0;
                                state_q <= S_P4;
                            end else if (ErrCheckEn && !legal_s) begin
                                err_q   <= 1'b1;
                                buf_q   <= '0;
                                cnt_q   <= '0;
                                state_q <= S_P4;
                            end else begin
                                state_q <= S_P6;
                            end
                        end
                    end
                    S_P6: begin
                        if (cnt_d == 4'd6) begin
                            if (dec_s.hit) begin
                                data_q  <= dec_s.data;
                                len_q   <= dec_s.len;
                                dv_q    <= 1'b1;
                                buf_q   <= '0;
                                cnt_q   <= '0;
                                state_q <= S_P4;
                            end else if (ErrCheckEn && !legal_s) begin
                                err_q   <= 1'b1;
                                buf_q   <= '0;
                                cnt_q   <= '0;
                                state_q <= S_P4;
                            end else begin
                                state_q <= S_P8;
                            end
                        end
                    end
                    S_P8: begin
                        if (cnt_d == 4'd8) begin
                            if (dec_s.hit) begin
                                data_q <= dec_s.data;
                                len_q  <= dec_s.len;
                                dv_q   <= 1'b1;
                            end else begin
                                err_q  <= ErrCheckEn;
                            end
                            buf_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= S_P4;
                        end
                    end
                    default: begin
                        buf_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_P4;
                    end
                endcase
            end
        end
    end

    assign data_o       = data_q;
    assign len_o        = len_q;
    assign data_valid_o = dv_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_rll_decoder.sv
// Directed, table-driven bench for rll_decoder; expectations follow the
// RLL_DEC_ERR_CHECK_EN setting of the build.
module tb_rll_decoder;

`ifdef RLL_DEC_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       line_i;
    logic       line_valid_i;
    logic       sync_i;
    logic [3:0] data_o;
    logic [2:0] len_o;
    logic       data_valid_o;
    logic       err_o;

    always #5 clk = ~clk;

    rll_decoder dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .line_i       (line_i),
        .line_valid_i (line_valid_i),
        .sync_i       (sync_i),
        .data_o       (data_o),
        .len_o        (len_o),
        .data_valid_o (data_valid_o),
        .err_o        (err_o)
    );

    typedef struct {
        logic [3:0] d;
        logic [2:0] l;
        int         c;
    } pulse_t;

    typedef struct {
        string       name;
        int          n;
        logic [15:0] bits;
        int          p;
        int          d0;
        int          l0;
        int          d;
        int          l;
        int          e;
        int          e_at;
    } vec_t;

    int     cyc = 0;
    int     err_n = 0;
    int     err_c = 0;
    pulse_t pq[$];
    pulse_t mon_p;
    int     n_chk = 0;
    int     n_fail = 0;
    int     last_s;
    int     samp[16];
    vec_t   vt[9];
    int     base_p;
    int     base_e;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid_o) begin
            mon_p.d = data_o;
            mon_p.l = len_o;
            mon_p.c = cyc;
            pq.push_back(mon_p);
        end
        if (err_o) begin
            err_n = err_n + 1;
            err_c = cyc;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_chk = n_chk + 1;
        if (got != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        line_i       = b;
        line_valid_i = 1'b1;
        @(posedge clk);
        #1;
        last_s = cyc;
    endtask

    task automatic idle(input int n);
        line_valid_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        line_valid_i = 1'b0;
        sync_i       = 1'b0;
        rst_ni       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_ni       = 1'b0;
        line_i       = 1'b0;
        line_valid_i = 1'b0;
        sync_i       = 1'b0;

        // bits are listed in channel order, right-aligned in the literal
        vt[0] = '{"v031",   4,  16'b000000000000_1111, 1, 3, 2, 3, 2, 0, 0};
        vt[1] = '{"v032",   10, 16'b000000_0111111000, 2, 2, 2, 0, 3, 0, 0};
        vt[2] = '{"v033",   8,  16'b00000000_00111000, 1, 2, 4, 2, 4, 0, 0};
        vt[3] = '{"w011",   6,  16'b0000000000_001111, 1, 3, 3, 3, 3, 0, 0};
        vt[4] = '{"w010",   6,  16'b0000000000_111000, 1, 2, 3, 2, 3, 0, 0};
        vt[5] = '{"w0011",  8,  16'b00000000_00001111, 1, 3, 4, 3, 4, 0, 0};
        vt[6] = '{"b2b",    14, 16'b00_11111000000111, 3, 3, 2, 0, 3, 0, 0};
        vt[7] = '{"v034",   4,  16'b000000000000_1000, 0, 0, 0, 0, 0,
                  ERR_EN ? 1 : 0, 4};
        vt[8] = '{"drop8",  12, 16'b0000_000000001111, 1, 3, ERR_EN ? 3 : 2,
                  3, ERR_EN ? 3 : 2, ERR_EN ? 1 : 0, 6};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_data", data_o, 0);
        chk("reset_len", len_o, 0);
        chk("reset_dv", data_valid_o, 0);
        chk("reset_err", err_o, 0);
        rst_ni = 1'b1;

        for (int k = 0; k < 9; k++) begin
            do_reset();
            base_p = pq.size();
            base_e = err_n;
            for (int i = 0; i < vt[k].n; i++) begin
                send_bit(vt[k].bits[vt[k].n - 1 - i]);
                samp[i] = last_s;
            end
            idle(4);
            chk({vt[k].name, "_pulses"}, pq.size() - base_p, vt[k].p);
            chk({vt[k].name, "_data"}, data_o, vt[k].d);
            chk({vt[k].name, "_len"}, len_o, vt[k].l);
            chk({vt[k].name, "_errs"}, err_n - base_e, vt[k].e);
            if (vt[k].p > 0 && pq.size() > base_p) begin
                chk({vt[k].name, "_first_data"}, pq[base_p].d, vt[k].d0);
                chk({vt[k].name, "_first_len"}, pq[base_p].l, vt[k].l0);
                chk({vt[k].name, "_latency"}, pq[pq.size() - 1].c, samp[vt[k].n - 1] + 1);
            end
            if (vt[k].e > 0 && err_n > base_e) begin
                chk({vt[k].name, "_err_latency"}, err_c, samp[vt[k].e_at - 1] + 1);
            end
        end

        // Reset in the middle of a codeword, with non-zero outputs held from before.
        send_bit(1'b0);
        send_bit(1'b1);
        line_valid_i = 1'b0;
        rst_ni = 1'b0;
        #2;
        chk("midrst_data", data_o, 0);
        chk("midrst_len", len_o, 0);
        chk("midrst_dv", data_valid_o, 0);
        chk("midrst_err", err_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        base_p = pq.size();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        idle(3);
        chk("midrst_pulses", pq.size() - base_p, 1);
        chk("midrst_after_data", data_o, 3);
        chk("midrst_after_len", len_o, 2);

        // Sync with a coincident bit, then a gapped codeword.
        do_reset();
        base_p = pq.size();
        base_e = err_n;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        sync_i       = 1'b1;
        line_i       = 1'b1;
        line_valid_i = 1'b1;
        @(posedge clk);
        #1;
        sync_i = 1'b0;
        send_bit(1'b1);
        idle(2);
        send_bit(1'b1);
        idle(1);
        send_bit(1'b1);
        idle(3);
        send_bit(1'b1);
        idle(3);
        chk("sync_pulses", pq.size() - base_p, 1);
        chk("sync_data", data_o, 3);
        chk("sync_len", len_o, 2);
        chk("sync_errs", err_n - base_e, 0);
        if (pq.size() > base_p) begin
            chk("sync_latency", pq[pq.size() - 1].c, last_s + 1);
        end
        idle(5);
        chk("hold_data", data_o, 3);
        chk("hold_len", len_o, 2);
        chk("hold_dv", data_valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rll_decoder.md
RLL_DECODER -- requirements
Module: rll_decoder

Interface
REQ-001 The block SHALL be clocked by a single clock and SHALL use an asynchronous, active-low reset.
REQ-002 Port: clk_i  in  1  system clock, all state updates on rising edge.
REQ-003 Port: rst_ni  in  1  asynchronous active-low reset.
REQ-004 Port: line_i  in  1  NRZI channel level, one channel bit per strobe.
REQ-005 Port: line_valid_i  in  1  line_i holds a new channel bit this cycle.
REQ-006 Port: sync_i  in  1  resync pulse; the next valid bit starts a codeword.
REQ-007 Port: data_o  out  4  decoded bits, LSB-aligned; first-decoded bit at position len_o-1.
REQ-008 Port: len_o  out  3  count of valid bits in data_o (2, 3 or 4).
REQ-009 Port: data_valid_o  out  1  one-cycle pulse; data_o/len_o carry a new codeword.
REQ-010 Port: err_o  out  1  one-cycle pulse; illegal codeword detected.

Function
REQ-011 Each valid cycle SHALL form a code bit = line_i XOR ref_level; ref_level then takes line_i.
REQ-012 Code bits SHALL shift into an 8-bit buffer; bit_cnt (0..8) SHALL count bits of the current codeword.
REQ-013 Decode table, code -> data: 1000->11, 0100->10, 001000->011, 100100->010, 000100->000, 00100100->0010, 00001000->0011.
REQ-014 FSM states: S_P4 (collect to 4 bits), S_P6 (to 6), S_P8 (to 8); reset state S_P4.
REQ-015 S_P4 at bit_cnt=4: 2-bit match -> emit and return to S_P4 with bit_cnt=0; otherwise -> S_P6.
REQ-016 S_P6 at bit_cnt=6: 3-bit match -> emit and go to S_P4; otherwise -> S_P8.
REQ-017 S_P8 at bit_cnt=8: 4-bit match -> emit; no match -> discard; both go to S_P4.
REQ-018 Latency: data_valid_o SHALL rise exactly one cycle after the edge that samples the codeword's last channel bit.
REQ-019 data_o and len_o SHALL hold their last value between data_valid_o pulses.
REQ-020 Cycles with line_valid_i=0 SHALL leave all state unchanged; gaps of any length are legal.
REQ-021 A sync_i pulse SHALL clear the buffer and bit_cnt and set the FSM to S_P4, keeping ref_level.
REQ-022 When sync_i and line_valid_i are both high, sync_i SHALL take priority and the channel bit SHALL be dropped without updating ref_level.
REQ-023 Back-to-back codewords at one bit per cycle SHALL decode with no lost bits.

Reset
REQ-024 Reset SHALL set data_o=0, len_o=0, data_valid_o=0, err_o=0, ref_level=0, buffer=0, bit_cnt=0, FSM=S_P4.
REQ-025 Reset mid-codeword SHALL discard the partial codeword; the first valid bit after release starts a new codeword.

Configuration
REQ-026 Macro RLL_DEC_ERR_CHECK_EN SHALL control early illegal-prefix detection.
REQ-027 With the macro defined:
- At bit_cnt=4, a non-matching prefix not in {0010, 1001, 0001, 0000} SHALL pulse err_o and restart in S_P4.
- At bit_cnt=6, a non-matching prefix not in {001001, 000010} SHALL do the same.
- An unmatched 8-bit word SHALL pulse err_o.
- err_o SHALL rise with the same one-cycle latency as data_valid_o.
REQ-028 Without the macro: err_o SHALL be tied 0, no early checks SHALL run, and unmatched words SHALL be dropped silently at bit_cnt=8.

Structure
REQ-029 Package rll_pkg SHALL hold:
- the codeword/data constant table;
- FSM state enum;
- widths: code buffer 8, data 4, length 3.
REQ-030 Sub-module nrzi_edge_det SHALL own ref_level and produce the code bit plus its valid strobe.

Verification
REQ-031 Reset, then line 1,1,1,1 -> data_o=0011, len_o=2, one pulse.
REQ-032 Line 0,1,1,1,1,1,1,0,0,0 -> pulse data_o=0010/len 2, then pulse data_o=0000/len 3.
REQ-033 Line 0,0,1,1,1,0,0,0 -> single pulse data_o=0010, len_o=4, none earlier.
REQ-034 Line 1,0,0,0 (code 1100):
- Macro set -> err_o pulse one cycle after bit 4, no data_valid_o.
- Macro unset -> no pulse until bit 8.
REQ-035 Two bits, rst_ni low, then 1,1,1,1 -> outputs 0 during reset, then data_o=0011/len 2.
REQ-036 sync_i with line_valid_i high after 3 bits, then 1,1,1,1 with gaps -> data_o=0011/len 2; the dropped bit has no effect.
